dm_arbiter: RTL

Shares the single-port data memory between the pipeline's M stage (CPU port) and a block-copy/DMA engine (burst port). CPU accesses have priority and complete in the cycle they are granted. Bursts proceed one word per free cycle. A starvation counter guarantees burst progress. The block sits between the M-stage register outputs and the data-memory array, and drives the pipeline stall.

---
 rtl/dm_arb_pkg.sv | 19 +
 rtl/dm_burst_gen.sv | 32 +++
 rtl/dm_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/dm_arb_pkg.sv
// rtl/dm_arb_pkg.sv - shared types and defaults for the data-memory arbiter
package dm_arb_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BURST = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam int DM_WORDS_DEF     = 3072;
   localparam int MAX_LEN_DEF      = 8;
   localparam int STARVE_LIMIT_DEF = 4;
   localparam int WIDX_W           = 12;

   function automatic logic [WIDX_W-1:0] word_idx(input logic [31:0] byte_addr);
      return byte_addr[13:2];
   endfunction

endpackage

// File: rtl/dm_burst_gen.sv
// rtl/dm_burst_gen.sv - burst word pointer and remaining-beat counter
module dm_burst_gen (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_load,
   input  logic [29:0] i_addr,
   input  logic [3:0]  i_len,
   input  logic        i_advance,
   output logic [29:0] o_cur,
   output logic        o_last
);

   logic [29:0] r_cur;
   logic [3:0]  r_rem;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cur <= '0;
         r_rem <= '0;
      end else if (i_load) begin
         r_cur <= i_addr;
         r_rem <= i_len;
      end else if (i_advance) begin
         r_cur <= r_cur + 30'd1;
         r_rem <= r_rem - 4'd1;
      end
   end

   assign o_cur  = r_cur;
   assign o_last = (r_rem == 4'd1);

endmodule

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - CPU/burst arbiter for the single-port data memory
// CPU wins each cycle unless the burst has been denied STARVE_LIMIT times in a row.
module dm_arbiter
   import dm_arb_pkg::*;
#(
   parameter int DM_WORDS     = DM_WORDS_DEF,
   parameter int MAX_LEN      = MAX_LEN_DEF,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        c_req,
   input  logic        c_we,
   input  logic [31:0] c_addr,
   input  logic [31:0] c_wd,
   output logic [31:0] c_rd,
   output logic        c_stall,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [3:0]  d_len,
   input  logic [31:0] d_wd,
   output logic [31:0] d_rd,
   output logic        d_ack,
   output logic        d_busy,
   output logic        d_done,
   output logic        d_err,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);

   state_t        r_state;
   logic          r_we;
   logic          r_err;
   logic [SW-1:0] r_starve;

   logic        w_len_ok, w_start, w_in_burst, w_force;
   logic        w_cpu_gnt, w_d_gnt, w_c_oor, w_d_oor, w_last;
   logic [29:0] w_cur;
   logic        w_unused;

   assign w_unused   = &{1'b0, d_addr[1:0]};
   assign w_len_ok   = (d_len != 4'd0) && (32'(d_len) <= MAX_LEN);
   assign w_start    = (r_state == S_IDLE) && d_req && w_len_ok;
   assign w_in_burst = (r_state == S_BURST);
   assign w_force    = w_in_burst && (r_starve == SW'(STARVE_LIMIT));
   assign w_cpu_gnt  = c_req && !w_force;
   assign w_d_gnt    = w_in_burst && !w_cpu_gnt;
   assign w_c_oor    = (32'(word_idx(c_addr)) >= DM_WORDS);
   assign w_d_oor    = (32'(w_cur[WIDX_W-1:0]) >= DM_WORDS);

   dm_burst_gen u_gen (
      .clk       (clk),
      .reset     (reset),
      .i_load    (w_start),
      .i_addr    (d_addr[31:2]),
      .i_len     (d_len),
      .i_advance (w_d_gnt),
      .o_cur     (w_cur),
      .o_last    (w_last)
   );

   // Out-of-range accesses never write and read back as zero.
   always_comb begin
      mem_we   = 1'b0;
      mem_addr = '0;
      mem_wd   = '0;
      c_rd     = '0;
      d_rd     = '0;
      if (w_cpu_gnt) begin
         mem_addr = c_addr;
         mem_we   = c_we && !w_c_oor;
         mem_wd   = c_wd;
         c_rd     = w_c_oor ? 32'd0 : mem_rd;
      end else if (w_d_gnt) begin
         mem_addr = {w_cur, 2'b00};
         mem_we   = r_we && !w_d_oor;
         mem_wd   = d_wd;
         d_rd     = w_d_oor ? 32'd0 : mem_rd;
      end
   end

   assign c_stall = c_req && w_force;
   assign d_ack   = w_d_gnt;
   assign d_busy  = (r_state == S_BURST);
   assign d_done  = (r_state == S_DONE);
   assign d_err   = r_err;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_we     <= 1'b0;
         r_err    <= 1'b0;
         r_starve <= '0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_starve <= '0;
               if (d_req) begin
                  if (w_len_ok) begin
                     r_we    <= d_we;
                     r_state <= S_BURST;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            S_BURST: begin
               if (w_d_gnt) begin
                  r_starve <= '0;
                  if (w_last) r_state <= S_DONE;
               end else if (r_starve != SW'(STARVE_LIMIT)) begin
                  r_starve <= r_starve + SW'(1);
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
